decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of register-file entries and read values.
REQ-002 Parameter FWD_EN, default 0, 1 = forwarding unit present downstream (stall only on load-use).
REQ-003 Parameter RF_INIT_IDX, default 0, 1 = register i resets to value i, 0 = resets to zero.
REQ-004 clk  in  1  rising-edge clock; reset is synchronous and active-high.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 freeze  in  1  hold ID/EX register contents (downstream memory stall).
REQ-007 flush  in  1  branch taken; kill the instruction entering ID/EX.
REQ-008 valid_in  in  1, pc_in  in  32, instr_in  in  32  from IF/ID.
REQ-009 flags_in  in  4  {N,Z,C,V} from status register.
REQ-010 wb_en  in  1, wb_dest  in  4, wb_value  in  DATA_W  write-back port.
REQ-011 exe_wb_en  in  1, exe_dest  in  4, exe_mem_r  in  1, mem_wb_en  in  1, mem_dest  in  4  hazard inputs.
REQ-012 hazard  out  1  combinational; IF and IF/ID hold while high.
REQ-013 Registered outputs: valid_out 1, pc_out 32, val_rn DATA_W, val_rm DATA_W, imm 1, shift_op 12, simm24 24, dest 4, src1 4, src2 4, two_src 1, wb_en_out 1, mem_r_out 1, mem_w_out 1, exe_cmd 4, b_out 1, s_out 1, flags_out 4.

Function
REQ-014 Fields: cond=[31:28], I=[25], mode=[27:26], opcode=[24:21], S=[20], Rn=[19:16], Rd=[15:12], Rm=[3:0].
REQ-015 src1=Rn; src2=Rd when store (mode 01, S=0), else Rm; two_src = store OR NOT I.
REQ-016 Mode 00 exe_cmd: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110; wb_en except CMP/TST; s_out=S. Other opcodes: all control zero.
REQ-017 Mode 01: LDR (S=1) wb_en, mem_r, exe_cmd 0010; STR (S=0) mem_w, exe_cmd 0010; s_out 0. Mode 10: b_out 1 only. Mode 11: all control zero.
REQ-018 Condition: standard ARM EQ..LE on flags_in, 1110 always passes, 1111 always fails; failed condition zeroes wb_en, mem_r, mem_w, b, s, exe_cmd.
REQ-019 Register file: 16 x DATA_W, two async read ports (src1, src2), one write port at rising clk when wb_en.
REQ-020 Write-read bypass: read address equal to wb_dest with wb_en returns wb_value same cycle.
REQ-021 FWD_EN=0: hazard = valid_in AND ((exe_wb_en AND exe_dest matches src1, or src2 when two_src) OR same for mem_wb_en/mem_dest).
REQ-022 FWD_EN=1: hazard = valid_in AND exe_mem_r AND exe_dest matches src1 (or src2 when two_src).
REQ-023 Branch (mode 10) and mode 11 never raise hazard.
REQ-024 ID/EX update priority per edge: rst > flush (bubble) > freeze (hold) > hazard (bubble) > load.
REQ-025 Bubble: valid_out 0 and all control outputs 0; data outputs don't-care.
REQ-026 Load: every output takes decoded value; valid_out=valid_in; invalid input loads zero control.
REQ-027 Latency: instruction present at instr_in appears on outputs one cycle later; hazard zero-latency.
REQ-028 flush with freeze simultaneously: bubble wins.

Reset
REQ-029 On rst: all registered outputs 0, valid_out 0; register i = (RF_INIT_IDX ? i : 0); wb write that cycle ignored.
REQ-030 rst mid-stall clears outputs; hazard remains combinational on inputs.

Structure
REQ-031 Shared package decode_pkg: exe_cmd encodings, opcode constants, mode constants, cond codes.
REQ-032 One sub-module regfile_bypass (16 x DATA_W, bypass, reset init); decode, condition, hazard logic inline.

Verification
REQ-033 Write R3=0x55 via wb port, next cycle decode ADD R1,R2,R3 -> val_rm=0x55, exe_cmd 0010, wb_en_out 1.
REQ-034 Same-cycle wb_en R2=0xAA while decoding src1=R2 -> val_rn=0xAA.
REQ-035 FWD_EN=0, exe_wb_en=1 exe_dest=2, decode SUB using Rn=2 -> hazard 1, next valid_out 0, control 0.
REQ-036 FWD_EN=1, same stimulus with exe_mem_r=0 -> hazard 0; with exe_mem_r=1 -> hazard 1.
REQ-037 cond=0000 (EQ), Z=0, MOV -> valid_out 1, all control 0; freeze=1 two cycles -> outputs held; flush -> valid_out 0.
REQ-038 rst asserted mid-sequence -> next edge all outputs 0, R5 reads 0 (RF_INIT_IDX=0) or 5 (=1).

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: ALU command codes, opcode, mode
// and condition constants, control/info bundles.
package decode_pkg;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r;
    logic       mem_w;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        imm;
    logic [11:0] shift_op;
    logic [23:0] simm24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        two_src;
    logic [3:0]  flags;
  } info_t;

  // flags are {N,Z,C,V}
  function automatic logic cond_pass(
    input logic [3:0] cond,
    input logic [3:0] f
  );
    logic n, z, c, v, p;
    {n, z, c, v} = f;
    unique case (cond)
      COND_EQ: p = z;
      COND_NE: p = !z;
      COND_CS: p = c;
      COND_CC: p = !c;
      COND_MI: p = n;
      COND_PL: p = !n;
      COND_VS: p = v;
      COND_VC: p = !v;
      COND_HI: p = c && !z;
      COND_LS: p = !c || z;
      COND_GE: p = (n == v);
      COND_LT: p = (n != v);
      COND_GT: p = !z && (n == v);
      COND_LE: p = z || (n != v);
      COND_AL: p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// 16-entry register file, two async reads, one write,
// write-to-read bypass and selectable reset image.
module regfile_bypass #(
  parameter int DATA_W   = 32,
  parameter int INIT_IDX = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        raddr1,
  input  logic [3:0]        raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [15:0][DATA_W-1:0] mem_q;
  logic [15:0][DATA_W-1:0] mem_d;

  // next register image from the write port
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // storage; reset overrides any same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= (INIT_IDX != 0) ? DATA_W'(i) : '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata1 = (we && waddr == raddr1) ? wdata
                                          : mem_q[raddr1];
  assign rdata2 = (we && waddr == raddr2) ? wdata
                                          : mem_q[raddr2];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode: field split, condition check, hazard
// detection, register read and the ID/EX pipeline register.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int FWD_EN      = 0,
  parameter int RF_INIT_IDX = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       instr_in,
  input  logic [3:0]        flags_in,
  input  logic              wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              exe_wb_en,
  input  logic [3:0]        exe_dest,
  input  logic              exe_mem_r,
  input  logic              mem_wb_en,
  input  logic [3:0]        mem_dest,
  output logic              hazard,
  output logic              valid_out,
  output logic [31:0]       pc_out,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic              imm,
  output logic [11:0]       shift_op,
  output logic [23:0]       simm24,
  output logic [3:0]        dest,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic              two_src,
  output logic              wb_en_out,
  output logic              mem_r_out,
  output logic              mem_w_out,
  output logic [3:0]        exe_cmd,
  output logic              b_out,
  output logic              s_out,
  output logic [3:0]        flags_out
);

  logic [3:0] cond, opcode, rn, rd, rm;
  logic [1:0] mode;
  logic       i_bit, s_bit;
  logic       is_dp, is_mem, is_br, store;
  logic [3:0] s1, s2;
  logic       two;
  logic [DATA_W-1:0] rd1, rd2;
  ctrl_t dec, ctrl_ld;
  logic  exe_hit, mem_hit, hz;

  assign cond   = instr_in[31:28];
  assign mode   = instr_in[27:26];
  assign i_bit  = instr_in[25];
  assign opcode = instr_in[24:21];
  assign s_bit  = instr_in[20];
  assign rn     = instr_in[19:16];
  assign rd     = instr_in[15:12];
  assign rm     = instr_in[3:0];

  assign is_dp  = (mode == MODE_DP);
  assign is_mem = (mode == MODE_MEM);
  assign is_br  = (mode == MODE_BR);
  assign store  = is_mem && !s_bit;
  assign s1     = rn;
  assign s2     = store ? rd : rm;
  assign two    = store || !i_bit;

  regfile_bypass #(
    .DATA_W  (DATA_W),
    .INIT_IDX(RF_INIT_IDX)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_en),
    .waddr (wb_dest),
    .wdata (wb_value),
    .raddr1(s1),
    .raddr2(s2),
    .rdata1(rd1),
    .rdata2(rd2)
  );

  // raw control decode from mode/opcode/S
  always_comb begin
    dec = '0;
    unique case (1'b1)
      is_dp: begin
        unique case (opcode)
          OP_MOV:  dec.exe_cmd = EXE_MOV;
          OP_MVN:  dec.exe_cmd = EXE_MVN;
          OP_ADD:  dec.exe_cmd = EXE_ADD;
          OP_ADC:  dec.exe_cmd = EXE_ADC;
          OP_SUB:  dec.exe_cmd = EXE_SUB;
          OP_SBC:  dec.exe_cmd = EXE_SBC;
          OP_AND:  dec.exe_cmd = EXE_AND;
          OP_ORR:  dec.exe_cmd = EXE_ORR;
          OP_EOR:  dec.exe_cmd = EXE_EOR;
          OP_CMP:  dec.exe_cmd = EXE_SUB;
          OP_TST:  dec.exe_cmd = EXE_AND;
          default: dec.exe_cmd = EXE_NOP;
        endcase
        dec.wb_en = (dec.exe_cmd != EXE_NOP)
                 && (opcode != OP_CMP)
                 && (opcode != OP_TST);
        dec.s = s_bit && (dec.exe_cmd != EXE_NOP);
      end
      is_mem: begin
        dec.exe_cmd = EXE_ADD;
        dec.wb_en   = s_bit;
        dec.mem_r   = s_bit;
        dec.mem_w   = !s_bit;
      end
      is_br: begin
        dec.b = 1'b1;
      end
      default: begin
        dec = '0;
      end
    endcase
  end

  assign ctrl_ld = (valid_in && cond_pass(cond, flags_in))
                 ? dec : '0;

  // stall request; branches and mode 11 read nothing
  always_comb begin
    exe_hit = (exe_dest == s1) || (two && exe_dest == s2);
    mem_hit = (mem_dest == s1) || (two && mem_dest == s2);
    if (FWD_EN != 0) begin
      hz = exe_mem_r && exe_hit;
    end else begin
      hz = (exe_wb_en && exe_hit)
        || (mem_wb_en && mem_hit);
    end
    hazard = valid_in && (is_dp || is_mem) && hz;
  end

  logic              valid_q, valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  info_t             info_q, info_d;
  logic [DATA_W-1:0] rn_q, rn_d, rm_q, rm_d;

  // ID/EX next state: flush > freeze > hazard > load
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    info_d  = info_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    priority case (1'b1)
      flush: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
      freeze: begin
      end
      hazard: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
      default: begin
        valid_d         = valid_in;
        ctrl_d          = ctrl_ld;
        info_d.pc       = pc_in;
        info_d.imm      = i_bit;
        info_d.shift_op = instr_in[11:0];
        info_d.simm24   = instr_in[23:0];
        info_d.dest     = rd;
        info_d.src1     = s1;
        info_d.src2     = s2;
        info_d.two_src  = two;
        info_d.flags    = flags_in;
        rn_d            = rd1;
        rm_d            = rd2;
      end
    endcase
  end

  // ID/EX register with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      info_q  <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      info_q  <= info_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
    end
  end

  assign valid_out = valid_q;
  assign pc_out    = info_q.pc;
  assign val_rn    = rn_q;
  assign val_rm    = rm_q;
  assign imm       = info_q.imm;
  assign shift_op  = info_q.shift_op;
  assign simm24    = info_q.simm24;
  assign dest      = info_q.dest;
  assign src1      = info_q.src1;
  assign src2      = info_q.src2;
  assign two_src   = info_q.two_src;
  assign flags_out = info_q.flags;
  assign wb_en_out = ctrl_q.wb_en;
  assign mem_r_out = ctrl_q.mem_r;
  assign mem_w_out = ctrl_q.mem_w;
  assign exe_cmd   = ctrl_q.exe_cmd;
  assign b_out     = ctrl_q.b;
  assign s_out     = ctrl_q.s;

endmodule
